bram_port_arb: RTL and testbench
================================

Name: bram_port_arb

Overview:
- Two-requester round-robin arbiter and initialiser for one port of a 1024x18 dual-port block RAM: 16 data bits plus 2 parity bits, 1-cycle synchronous read.
- After reset it sweeps the whole array to INIT_VALUE. It then shares the RAM port between requesters R0 and R1 using a req/gnt handshake and returns read data with a registered valid.
- Sits between two client pipelines and the RAM wrapper's A (or B) port. The other RAM port is untouched.

Parameters:
- ADDR_W, 10, RAM address width; the array depth is 2**ADDR_W.
- DATA_W, 16, data width. Must be 16: two bytes, one parity bit per byte.
- INIT_VALUE, 16'h0000, data word written to every location during init.

Ports:
- clk  in  1  single clock for the block and the RAM port.
- rst_n  in  1  asynchronous active-low reset.
- r0_req, r1_req  in  1 each  access request; held with its fields stable until granted.
- r0_we, r1_we  in  1 each  1 = write, 0 = read.
- r0_addr, r1_addr  in  ADDR_W each  access address.
- r0_wdata, r1_wdata  in  DATA_W each  write data.
- r0_gnt, r1_gnt  out  1 each  combinational accept; the transfer happens on a cycle with req & gnt.
- r0_rvalid, r1_rvalid  out  1 each  read data valid, registered.
- rdata  out  DATA_W  shared read return; meaningful only while an rvalid is high.
- perr  out  1  read parity error; see Optional Feature.
- init_done  out  1  high once the init sweep is complete.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM port write enable.
- ram_ssr  out  1  RAM synchronous set/reset; tied 0.
- ram_addr  out  ADDR_W  RAM port address.
- ram_di  out  DATA_W  RAM port write data.
- ram_dip  out  2  RAM port parity in.
- ram_do  in  DATA_W  RAM port read data.
- ram_dop  in  2  RAM port parity out.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=INIT, init counter=0, rr_last=1 (so R0 wins the first tie), r0_rvalid=r1_rvalid=0, perr=0, init_done=0.
- Outputs from state and counter while in reset: ram_en=1, ram_we=1, ram_addr=0, ram_di=INIT_VALUE; both gnt=0.
- FSM, two states:
  - INIT: ram_en=1, ram_we=1, ram_addr=counter, ram_di=INIT_VALUE; counter increments each cycle.
  - INIT exit: when counter==2**ADDR_W-1, that location is written and the next state is RUN; init_done rises at the same edge.
  - Init duration: exactly 2**ADDR_W cycles after rst_n deassertion (1024 at default).
  - During INIT both gnt=0 regardless of req.
  - RUN: sel = R0 if only r0_req; R1 if only r1_req; if both, the requester other than rr_last.
  - Grant: gnt_sel=1, ram_en=1, ram_we=sel_we, ram_addr=sel_addr, ram_di=sel_wdata.
  - rr_last <= sel on every grant.
  - No request: ram_en=0, ram_we=0, gnt=0, rr_last unchanged.
  - RUN is left only by reset.
- Throughput: one access per cycle, back-to-back. Under continuous contention, grants alternate R0, R1, R0, ...
- Read latency: a read granted in cycle T has rvalid_sel=1 in cycle T+1 only (single-cycle pulse), with rdata=ram_do passed through combinationally in T+1.
  - At most one rvalid is high in any cycle.
  - Writes never produce rvalid.
- Ordering: single port, so accesses are serialised in grant order. A read granted after a write to the same address, from either requester, returns the new data.
- Reset mid-operation: async assertion immediately clears rvalid, gnt, perr and init_done, and returns to INIT. Any in-flight read return is dropped and the sweep restarts at address 0.
- ram_ssr is constantly 0.

Optional Feature:
- Macro: BRAM_ARB_PARITY_EN.
- Defined, write path: ram_dip[1]=^wdata[15:8], ram_dip[0]=^wdata[7:0] (even parity). INIT writes the parity of INIT_VALUE.
- Defined, read path: in a cycle with rvalid=1, perr = (ram_dop[1] != ^ram_do[15:8]) | (ram_dop[0] != ^ram_do[7:0]); perr is combinational, 0 when no rvalid.
- Not defined: ram_dip=2'b00, perr tied 0, ram_dop ignored.

Test Plan:
- Reset, then hold r0_req=1 as a read of address 3FF from cycle 0 → no gnt for 1024 cycles. init_done rises after cycle 1023, gnt on cycle 1024, r0_rvalid the next cycle with rdata=16'h0000.
- After init, R0 writes A5C3 to address 010, then R1 reads 010 on the next cycle → R1 read granted, r1_rvalid one cycle later with rdata=A5C3.
- Both requesters hold read requests continuously for 6 cycles → gnt order R0, R1, R0, R1, R0, R1. Each rvalid lags its gnt by 1 cycle and r0_rvalid/r1_rvalid are never high together.
- R1 alone requests 3 reads, then both request → R1, R1, R1, then R0 wins the tie (rr_last=R1).
- Assert rst_n=0 in the cycle after a granted read → r0_rvalid stays 0 and init_done drops. After release, the init sweep repeats with ram_addr starting at 000.
- With BRAM_ARB_PARITY_EN: write 0x0100 → ram_dip=2'b10. Force ram_dop=2'b00 on its readback → perr=1 during the rvalid cycle. Without the macro → ram_dip=00, perr=0.

Source files
------------

// File: rtl/bram_port_arb.sv
// bram_port_arb: sweeps the RAM to INIT_VALUE after reset, then round-robins R0/R1 onto one BRAM port.
// Reads return one cycle after gnt; optional byte parity is enabled by BRAM_ARB_PARITY_EN.
module bram_port_arb #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 16,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r0_req,
   input  logic              r0_we,
   input  logic [ADDR_W-1:0] r0_addr,
   input  logic [DATA_W-1:0] r0_wdata,
   input  logic              r1_req,
   input  logic              r1_we,
   input  logic [ADDR_W-1:0] r1_addr,
   input  logic [DATA_W-1:0] r1_wdata,
   output logic              r0_gnt,
   output logic              r1_gnt,
   output logic              r0_rvalid,
   output logic              r1_rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              perr,
   output logic              init_done,
   output logic              ram_en,
   output logic              ram_we,
   output logic              ram_ssr,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_di,
   output logic [1:0]        ram_dip,
   input  logic [DATA_W-1:0] ram_do,
   input  logic [1:0]        ram_dop
);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t            state;
   logic [ADDR_W-1:0] cnt;
   logic              rr_last;
   logic              sel;
   logic              grant;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // sel = 0 picks R0, 1 picks R1; a tie goes to whoever did not win last
   always_comb begin
      sel       = (r0_req & r1_req) ? ~rr_last : r1_req;
      grant     = (state == S_RUN) & (r0_req | r1_req);
      sel_we    = sel ? r1_we    : r0_we;
      sel_addr  = sel ? r1_addr  : r0_addr;
      sel_wdata = sel ? r1_wdata : r0_wdata;
   end

   assign r0_gnt   = grant & ~sel;
   assign r1_gnt   = grant &  sel;
   assign ram_en   = (state == S_INIT) | grant;
   assign ram_we   = (state == S_INIT) | (grant & sel_we);
   assign ram_addr = (state == S_INIT) ? cnt : sel_addr;
   assign ram_di   = (state == S_INIT) ? INIT_VALUE : sel_wdata;
   assign ram_ssr  = 1'b0;
   assign rdata    = ram_do;

`ifdef BRAM_ARB_PARITY_EN
   assign ram_dip = {^ram_di[15:8], ^ram_di[7:0]};
   assign perr    = (r0_rvalid | r1_rvalid) &
                    ((ram_dop[1] != ^ram_do[15:8]) | (ram_dop[0] != ^ram_do[7:0]));
`else
   logic unused_dop;
   assign unused_dop = ^ram_dop;
   assign ram_dip    = 2'b00;
   assign perr       = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_INIT;
         cnt       <= '0;
         rr_last   <= 1'b1;
         r0_rvalid <= 1'b0;
         r1_rvalid <= 1'b0;
         init_done <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               cnt       <= cnt + 1'b1;
               r0_rvalid <= 1'b0;
               r1_rvalid <= 1'b0;
               if (cnt == {ADDR_W{1'b1}}) begin
                  state     <= S_RUN;
                  init_done <= 1'b1;
               end
            end
            default: begin
               if (grant) rr_last <= sel;
               r0_rvalid <= grant & ~sel & ~sel_we;
               r1_rvalid <= grant &  sel & ~sel_we;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bram_port_arb.sv
// Bench for bram_port_arb: behavioural RAM, directed scenarios, then random traffic vs. a memory/arbitration model.
module tb_bram_port_arb;
   localparam int AW = 10;
   localparam int DEPTH = 1 << AW;
   localparam logic [15:0] IV = 16'h0000;

   logic clk = 1'b0;
   logic rst_n;
   logic r0_req, r0_we, r1_req, r1_we;
   logic [AW-1:0] r0_addr, r1_addr;
   logic [15:0] r0_wdata, r1_wdata;
   logic r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, perr, init_done;
   logic ram_en, ram_we, ram_ssr;
   logic [AW-1:0] ram_addr;
   logic [15:0] ram_di, ram_do, rdata;
   logic [1:0] ram_dip, ram_dop;

   bram_port_arb #(.ADDR_W(AW), .DATA_W(16), .INIT_VALUE(IV)) dut (
      .clk(clk), .rst_n(rst_n),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
      .r0_gnt(r0_gnt), .r1_gnt(r1_gnt), .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
      .rdata(rdata), .perr(perr), .init_done(init_done),
      .ram_en(ram_en), .ram_we(ram_we), .ram_ssr(ram_ssr), .ram_addr(ram_addr),
      .ram_di(ram_di), .ram_dip(ram_dip), .ram_do(ram_do), .ram_dop(ram_dop)
   );

   always #5 clk = ~clk;

   // behavioural block RAM, 1-cycle synchronous read; corrupt_dop zeroes returned parity
   logic [15:0] ram_mem [0:DEPTH-1];
   logic [1:0]  ram_par [0:DEPTH-1];
   logic        corrupt_dop = 1'b0;
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) begin
            ram_mem[ram_addr] <= ram_di;
            ram_par[ram_addr] <= ram_dip;
         end
         ram_do  <= ram_mem[ram_addr];
         ram_dop <= corrupt_dop ? 2'b00 : ram_par[ram_addr];
      end
   end

   int n_pass = 0;
   int n_total = 0;

   // reference model: expected array contents, last winner, pending read return
   logic [15:0] m_mem [0:DEPTH-1];
   int          m_last;
   logic        p0, p1, pbad;
   logic [15:0] pdat;
   int          g_hist[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) m_mem[i] = IV;
      m_last = 1;
      p0 = 1'b0; p1 = 1'b0; pbad = 1'b0; pdat = '0;
      g_hist.delete();
   endtask

   function automatic logic [1:0] par_of(input logic [15:0] d);
`ifdef BRAM_ARB_PARITY_EN
      return {^d[15:8], ^d[7:0]};
`else
      return 2'b00;
`endif
   endfunction

   task automatic init_sweep();
      int bad = 0;
      for (int c = 0; c < DEPTH; c++) begin
         @(negedge clk);
         if (c == 0) chk("init_first_addr", 32'(ram_addr), 32'h0);
         if (ram_addr !== AW'(c) || r0_gnt || r1_gnt || init_done || !ram_en || !ram_we ||
             ram_di !== IV || ram_dip !== par_of(IV) || r0_rvalid || r1_rvalid) bad++;
         @(posedge clk); #1;
      end
      chk("init_sweep_errs", 32'(bad), 32'h0);
      chk("init_done_rise", 32'(init_done), 32'h1);
      model_reset();
   endtask

   task automatic step(input logic q0, input logic w0, input logic [AW-1:0] a0, input logic [15:0] d0,
                       input logic q1, input logic w1, input logic [AW-1:0] a1, input logic [15:0] d1);
      int who;
      logic ew;
      logic [AW-1:0] ea;
      logic [15:0] ed;
      r0_req = q0; r0_we = w0; r0_addr = a0; r0_wdata = d0;
      r1_req = q1; r1_we = w1; r1_addr = a1; r1_wdata = d1;
      if (q0 && q1) who = (m_last == 0) ? 1 : 0;
      else if (q0)  who = 0;
      else if (q1)  who = 1;
      else          who = -1;
      ew = (who == 1) ? w1 : w0;
      ea = (who == 1) ? a1 : a0;
      ed = (who == 1) ? d1 : d0;
      @(negedge clk);
      chk("gnt0", 32'(r0_gnt), 32'(who == 0));
      chk("gnt1", 32'(r1_gnt), 32'(who == 1));
      chk("ram_en", 32'(ram_en), 32'(who >= 0));
      chk("rvalid0", 32'(r0_rvalid), 32'(p0));
      chk("rvalid1", 32'(r1_rvalid), 32'(p1));
      chk("one_rvalid", 32'(r0_rvalid & r1_rvalid), 32'h0);
      if (p0 || p1) chk("rdata", 32'(rdata), 32'(pdat));
`ifdef BRAM_ARB_PARITY_EN
      chk("perr", 32'(perr), 32'((p0 | p1) & pbad));
`else
      chk("perr", 32'(perr), 32'h0);
`endif
      chk("ram_ssr", 32'(ram_ssr), 32'h0);
      if (who >= 0) begin
         chk("ram_we", 32'(ram_we), 32'(ew));
         chk("ram_addr", 32'(ram_addr), 32'(ea));
         if (ew) begin
            chk("ram_di", 32'(ram_di), 32'(ed));
            chk("ram_dip", 32'(ram_dip), 32'(par_of(ed)));
         end
      end else begin
         chk("ram_we_idle", 32'(ram_we), 32'h0);
      end
      @(posedge clk); #1;
      p0 = (who == 0) && !ew;
      p1 = (who == 1) && !ew;
      pbad = corrupt_dop;
      if (who >= 0) begin
         if (!ew) pdat = m_mem[ea];
         else     m_mem[ea] = ed;
         m_last = who;
         g_hist.push_back(who);
      end
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      rst_n = 1'b0;
      r0_req = 1'b1; r0_we = 1'b0; r0_addr = 10'h3FF; r0_wdata = '0;
      r1_req = 1'b1; r1_we = 1'b0; r1_addr = '0;     r1_wdata = '0;
      model_reset();
      #1;
      chk("rst_gnt0", 32'(r0_gnt), 32'h0);
      chk("rst_gnt1", 32'(r1_gnt), 32'h0);
      chk("rst_ram_en", 32'(ram_en), 32'h1);
      chk("rst_ram_we", 32'(ram_we), 32'h1);
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_ram_di", 32'(ram_di), 32'(IV));
      chk("rst_rvalid", 32'({r0_rvalid, r1_rvalid}), 32'h0);
      chk("rst_init_done", 32'(init_done), 32'h0);
      chk("rst_perr", 32'(perr), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      r1_req = 1'b0;
      rst_n = 1'b1;
      init_sweep();

      // first grant right after init, read of the last swept location
      step(1'b1, 1'b0, 10'h3FF, '0, 1'b0, 1'b0, '0, '0);
      idle();

      // write by R0 then read-back by R1
      step(1'b1, 1'b1, 10'h010, 16'hA5C3, 1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h010, '0);
      idle();

      // continuous contention alternates
      g_hist.delete();
      for (int i = 0; i < 6; i++)
         step(1'b1, 1'b0, AW'(i), '0, 1'b1, 1'b0, AW'(16 + i), '0);
      idle();
      chk("alt_len", 32'(g_hist.size()), 32'd6);
      for (int i = 0; i < g_hist.size(); i++) chk("alt_order", 32'(g_hist[i]), 32'(i % 2));

      // R1 alone three times, then tie goes to R0
      g_hist.delete();
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
      step(1'b1, 1'b0, 10'h005, '0, 1'b1, 1'b0, 10'h006, '0);
      idle();
      chk("tie_len", 32'(g_hist.size()), 32'd4);
      chk("tie_after_r1", 32'(g_hist[3]), 32'd0);

      // parity generation and a corrupted readback
      step(1'b1, 1'b1, 10'h020, 16'h0100, 1'b0, 1'b0, '0, '0);
      corrupt_dop = 1'b1;
      step(1'b1, 1'b0, 10'h020, '0, 1'b0, 1'b0, '0, '0);
      corrupt_dop = 1'b0;
      idle();
      step(1'b1, 1'b0, 10'h020, '0, 1'b0, 1'b0, '0, '0);
      idle();

      // random traffic over a small address window for lots of collisions
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), 16'($urandom));
      idle();

      // reset while a read return is due
      step(1'b1, 1'b0, 10'h005, '0, 1'b0, 1'b0, '0, '0);
      r0_req = 1'b0; r1_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_rvalid0", 32'(r0_rvalid), 32'h0);
      chk("midrst_init_done", 32'(init_done), 32'h0);
      chk("midrst_ram_addr", 32'(ram_addr), 32'h0);
      r0_req = 1'b1;
      #1;
      chk("midrst_gnt0", 32'(r0_gnt), 32'h0);
      r0_req = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      init_sweep();
      step(1'b1, 1'b0, 10'h010, '0, 1'b1, 1'b0, 10'h020, '0);
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
